// File: rtl/key_filter_pkg.sv
// Shared definitions for the key debouncer: FSM encoding, key level constants and a
// small sizing helper.
package key_filter_pkg;

  // Debouncer FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,  // released, stable
    StFiltDn = 2'd1,  // press seen, filtering
    StDown   = 2'd2,  // pressed, stable
    StFiltUp = 2'd3   // release seen, filtering
  } key_st_e;

  // The button pulls the pin low when pressed.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Largest of three counts, used to size the shared counter width.
  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Three-flop input synchronizer for the raw key pin with edge detection on the
// settled copies. All flops reset to the released level so that a key held down
// through reset is seen as a fresh falling edge once reset is released.
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic fall_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // Shift the pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall_o = s3_q & ~s2_q;
  assign rise_o = ~s3_q & s2_q;

endmodule

// File: rtl/key_filter.sv
// Debouncer for one active-low push-button. key_flag strobes for one cycle on each
// accepted press or release; key_state holds the debounced level (0 = pressed).
// Optional build macro KEY_FILTER_AUTO_REPEAT_EN adds hold-to-repeat strobes while
// the key stays pressed.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC      = 1000000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

`ifdef KEY_FILTER_AUTO_REPEAT_EN
  localparam int unsigned CntMax = max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC);
`else
  localparam int unsigned CntMax = DEBOUNCE_CYC;
`endif
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] CntSat  = {CntW{1'b1}};

  // Counters stop at all-ones rather than wrapping.
  function automatic logic [CntW-1:0] sat_inc(logic [CntW-1:0] v);
    return (v == CntSat) ? v : v + 1'b1;
  endfunction

  logic fall, rise;

  key_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_i  (key_in),
    .fall_o (fall),
    .rise_o (rise)
  );

  key_st_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic            level_q, level_d;

`ifdef KEY_FILTER_AUTO_REPEAT_EN
  localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD_CYC - 1);

  // hold_q counts cycles spent in DOWN; rep_q marks that the first repeat has fired.
  logic [CntW-1:0] hold_q, hold_d;
  logic            rep_q, rep_d;
`else
  logic rpt_unused;
  assign rpt_unused = ^{REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC};
`endif

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    level_d = level_q;
`ifdef KEY_FILTER_AUTO_REPEAT_EN
    hold_d  = hold_q;
    rep_d   = rep_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StFiltDn;
          cnt_d   = '0;
        end
      end
      StFiltDn: begin
        // A rise coinciding with the terminal count still rejects the press.
        if (rise) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d = StDown;
          flag_d  = 1'b1;
          level_d = KEY_PRESSED;
`ifdef KEY_FILTER_AUTO_REPEAT_EN
          hold_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      StDown: begin
        if (rise) begin
          state_d = StFiltUp;
          cnt_d   = '0;
`ifdef KEY_FILTER_AUTO_REPEAT_EN
        end else if (hold_q == (rep_q ? PeriodLast : DelayLast)) begin
          flag_d = 1'b1;
          hold_d = '0;
          rep_d  = 1'b1;
        end else begin
          hold_d = sat_inc(hold_q);
`endif
        end
      end
      StFiltUp: begin
        // Hold count is frozen here so a bounce back to DOWN resumes the repeat cadence.
        if (fall) begin
          state_d = StDown;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
          flag_d  = 1'b1;
          level_d = KEY_RELEASED;
`ifdef KEY_FILTER_AUTO_REPEAT_EN
          hold_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      level_q <= KEY_RELEASED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      level_q <= level_d;
    end
  end

`ifdef KEY_FILTER_AUTO_REPEAT_EN
  // Auto-repeat hold counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign key_flag  = flag_q;
  assign key_state = level_q;

endmodule
